// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bundle for the data memory responder
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_mode_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        busy_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_mode_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_mode_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Fixed-latency data memory responder with byte/half/word loads and stores
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);
  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [30:0] DEPTH_LIM = 31'(DEPTH_WORDS);
  localparam bit         ZERO_LAT  = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_mode;
  logic        req_ready_q, busy_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             access;
  logic             a_we;
  logic [31:0]      a_addr;
  logic [31:0]      a_wdata;
  logic [2:0]       a_mode;
  logic             a_err;
  logic [IDX_W-1:0] a_idx;
  logic [3:0]       a_be;
  logic [31:0]      a_lanes;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      ld_data;
  logic [31:0]      resp_data;

  // With zero latency the access happens on the accepting edge, so the live request is used.
  always_comb begin
    access  = !rst_i && ((state == IDLE && bus.req_valid_i && ZERO_LAT) ||
                         (state == WAIT && cnt == 4'd0));
    a_we    = (state == IDLE) ? bus.req_we_i    : lat_we;
    a_addr  = (state == IDLE) ? bus.req_addr_i  : lat_addr;
    a_wdata = (state == IDLE) ? bus.req_wdata_i : lat_wdata;
    a_mode  = (state == IDLE) ? bus.req_mode_i  : lat_mode;
    a_idx   = a_addr[IDX_W+1:2];

    a_err = 1'b0;
    if (a_we ? (a_mode > 3'b010) : (a_mode == 3'b011 || a_mode[2:1] == 2'b11))
      a_err = 1'b1;
    if (a_mode[1:0] == 2'b01 && a_addr[0])
      a_err = 1'b1;
    if (a_mode[1:0] == 2'b10 && a_addr[1:0] != 2'b00)
      a_err = 1'b1;
    if ({1'b0, a_addr[31:2]} >= DEPTH_LIM)
      a_err = 1'b1;

    case (a_mode[1:0])
      2'b00:   begin a_be = 4'b0001 << a_addr[1:0];            a_lanes = {4{a_wdata[7:0]}};  end
      2'b01:   begin a_be = a_addr[1] ? 4'b1100 : 4'b0011;     a_lanes = {2{a_wdata[15:0]}}; end
      default: begin a_be = 4'b1111;                           a_lanes = a_wdata;            end
    endcase

    rd_word  = mem[a_idx];
    rd_shift = rd_word >> {a_addr[1:0], 3'b000};
    case (a_mode)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'b0, rd_shift[7:0]};
      3'b101:  ld_data = {16'b0, rd_shift[15:0]};
      default: ld_data = 32'b0;
    endcase
    resp_data = (a_err || a_we) ? 32'b0 : ld_data;
  end

  always_ff @(posedge clk_i) begin
    if (access && a_we && !a_err) begin
      for (int b = 0; b < 4; b++)
        if (a_be[b]) mem[a_idx][8*b +: 8] <= a_lanes[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid_i) begin
          lat_we      <= bus.req_we_i;
          lat_addr    <= bus.req_addr_i;
          lat_wdata   <= bus.req_wdata_i;
          lat_mode    <= bus.req_mode_i;
          cnt         <= CNT_INIT;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          if (ZERO_LAT) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= resp_data;
            resp_err_q   <= a_err;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= resp_data;
          resp_err_q   <= a_err;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (bus.resp_ready_i) begin
          state        <= IDLE;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'b0;
          resp_err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.busy_o       = busy_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_err_o   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Scoreboard bench for dmem_responder at LATENCY 2 and LATENCY 0
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst0;
  dmem_responder_if b2();
  dmem_responder_if b0();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (.clk_i(clk), .rst_i(rst2), .bus(b2));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (.clk_i(clk), .rst_i(rst0), .bus(b0));

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b2.resp_valid_o === 1'b1 && b2.resp_ready_i === 1'b1) begin
      if (q2.size() == 0) chk1("sb2_unexpected", 1'b1, 1'b0);
      else begin
        e = q2.pop_front();
        chk("sb2_rdata", b2.resp_rdata_o, e.rdata);
        chk1("sb2_err", b2.resp_err_o, e.err);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b0.resp_valid_o === 1'b1 && b0.resp_ready_i === 1'b1) begin
      if (q0.size() == 0) chk1("sb0_unexpected", 1'b1, 1'b0);
      else begin
        e = q0.pop_front();
        chk("sb0_rdata", b0.resp_rdata_o, e.rdata);
        chk1("sb0_err", b0.resp_err_o, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic txn2(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] m, input logic [31:0] er, input logic ee, input int hold);
    int n;
    logic [31:0] first;
    n = 0;
    @(negedge clk);
    while (b2.req_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk1("ready_timeout", 1'b0, 1'b1);
    b2.req_valid_i = 1'b1;
    b2.req_we_i    = we;
    b2.req_addr_i  = a;
    b2.req_wdata_i = wd;
    b2.req_mode_i  = m;
    q2.push_back({er, ee});
    @(posedge clk);
    #1;
    b2.req_valid_i = 1'b0;
    b2.req_we_i    = ~we;
    b2.req_addr_i  = 32'hFFFF_FFFC;
    b2.req_wdata_i = 32'h5A5A_5A5A;
    b2.req_mode_i  = 3'b111;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk1("lat_valid", b2.resp_valid_o, i == 3);
    end
    first = b2.resp_rdata_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk1("hold_valid", b2.resp_valid_o, 1'b1);
      chk("hold_rdata", b2.resp_rdata_o, first);
      chk1("hold_req_ready", b2.req_ready_o, 1'b0);
    end
    @(posedge clk);
    #1 b2.resp_ready_i = 1'b1;
    @(posedge clk);
    #1 b2.resp_ready_i = 1'b0;
    @(negedge clk);
    chk1("ready_after_consume", b2.req_ready_o, 1'b1);
    chk1("valid_after_consume", b2.resp_valid_o, 1'b0);
  endtask

  logic        v0_we    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] v0_addr  [4] = '{32'h20, 32'h24, 32'h20, 32'h24};
  logic [31:0] v0_wdata [4] = '{32'h1111_2222, 32'h3333_4444, 32'h0, 32'h0};
  logic [31:0] v0_exp   [4] = '{32'h0, 32'h0, 32'h1111_2222, 32'h3333_4444};

  initial begin
    {b2.req_valid_i, b2.req_we_i, b2.resp_ready_i} = 3'b000;
    {b0.req_valid_i, b0.req_we_i, b0.resp_ready_i} = 3'b000;
    b2.req_addr_i = 32'h0; b2.req_wdata_i = 32'h0; b2.req_mode_i = 3'b000;
    b0.req_addr_i = 32'h0; b0.req_wdata_i = 32'h0; b0.req_mode_i = 3'b000;
    rst2 = 1'b1;
    rst0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    rst0 = 1'b0;
    @(negedge clk);
    chk1("rst_req_ready", b2.req_ready_o, 1'b1);
    chk1("rst_resp_valid", b2.resp_valid_o, 1'b0);
    chk1("rst_busy", b2.busy_o, 1'b0);
    chk("rst_rdata", b2.resp_rdata_o, 32'h0);
    chk1("rst_err", b2.resp_err_o, 1'b0);

    txn2(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 0);
    txn2(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 0);
    txn2(1'b1, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0, 0);
    txn2(1'b1, 32'h13, 32'h0000_0080, 3'b000, 32'h0, 1'b0, 0);
    txn2(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, 0);
    txn2(1'b0, 32'h13, 32'h0, 3'b100, 32'h0000_0080, 1'b0, 0);
    txn2(1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_0000, 1'b0, 0);
    txn2(1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1, 0);
    txn2(1'b1, 32'h12, 32'hFFFF_FFFF, 3'b010, 32'h0, 1'b1, 0);
    txn2(1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_0000, 1'b0, 5);
    txn2(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_8000, 1'b0, 0);
    txn2(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000_8000, 1'b0, 0);
    txn2(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0);
    txn2(1'b1, 32'h10, 32'hFFFF_FFFF, 3'b011, 32'h0, 1'b1, 0);
    txn2(1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1, 0);
    txn2(1'b1, 32'h1010, 32'hFFFF_FFFF, 3'b010, 32'h0, 1'b1, 0);
    txn2(1'b1, 32'h10, 32'h0000_1234, 3'b001, 32'h0, 1'b0, 0);
    txn2(1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_1234, 1'b0, 0);

    // Store aborted by a reset while waiting for the array.
    chk1("abort_pre_ready", b2.req_ready_o, 1'b1);
    b2.req_valid_i = 1'b1;
    b2.req_we_i    = 1'b1;
    b2.req_addr_i  = 32'h10;
    b2.req_wdata_i = 32'h1234_5678;
    b2.req_mode_i  = 3'b010;
    @(posedge clk);
    #1 b2.req_valid_i = 1'b0;
    @(negedge clk);
    chk1("abort_busy", b2.busy_o, 1'b1);
    rst2 = 1'b1;
    @(posedge clk);
    #1 rst2 = 1'b0;
    @(negedge clk);
    chk1("abort_req_ready", b2.req_ready_o, 1'b1);
    chk1("abort_busy_clr", b2.busy_o, 1'b0);
    repeat (4) begin
      chk1("abort_no_resp", b2.resp_valid_o, 1'b0);
      @(negedge clk);
    end
    txn2(1'b0, 32'h10, 32'h0, 3'b010, 32'h8000_1234, 1'b0, 0);

    // Zero-latency responder, consumer always ready, requester always valid.
    b0.resp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("l0_issue_ready", b0.req_ready_o, 1'b1);
      b0.req_valid_i = 1'b1;
      b0.req_we_i    = v0_we[k];
      b0.req_addr_i  = v0_addr[k];
      b0.req_wdata_i = v0_wdata[k];
      b0.req_mode_i  = 3'b010;
      q0.push_back({v0_exp[k], 1'b0});
      @(posedge clk);
      @(negedge clk);
      chk1("l0_resp_valid", b0.resp_valid_o, 1'b1);
      chk1("l0_req_ready_low", b0.req_ready_o, 1'b0);
    end
    @(negedge clk);
    b0.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("q2_drained", q2.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the data array (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of wait cycles between request acceptance and the array access (0..15).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1 bit: the MEM stage presents a load or store.
REQ-006 SHALL have port req_ready_o, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we_i, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_addr_i, input, 32 bits: the byte address (the ALU value).
REQ-009 SHALL have port req_wdata_i, input, 32 bits: the store data (the rs2 value).
REQ-010 SHALL have port req_mode_i, input, 3 bits: the funct3 access mode.
REQ-011 SHALL have port resp_valid_o, output, 1 bit: a response is available.
REQ-012 SHALL have port resp_ready_i, input, 1 bit: the MEM stage consumes the response.
REQ-013 SHALL have port resp_rdata_o, output, 32 bits: the extended load data.
REQ-014 SHALL have port resp_err_o, output, 1 bit: the access faulted.
REQ-015 SHALL have port busy_o, output, 1 bit: a request is in flight; the hazard unit uses it to stall the pipeline.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP, with only these transitions:
- IDLE to WAIT on handshake (req_valid_i and req_ready_o both high) when LATENCY>0.
- IDLE to RESP on handshake when LATENCY=0.
- WAIT to RESP when the wait counter is 0.
- RESP to IDLE on resp_ready_i.
REQ-017 SHALL drive req_ready_o=1 only in IDLE, and busy_o=1 in WAIT and RESP.
REQ-018 SHALL latch we, addr, wdata and mode on handshake, and load the wait counter with LATENCY-1.
REQ-019 SHALL decrement the wait counter by 1 per cycle in WAIT; the counter SHALL NOT wrap below 0.
REQ-020 SHALL give resp_valid_o=1 exactly LATENCY+1 cycles after the handshake cycle, and hold it there.
REQ-021 SHALL keep resp_valid_o, resp_rdata_o and resp_err_o stable in RESP until resp_ready_i=1.
REQ-022 SHALL return req_ready_o=1 in the cycle after the response is consumed, giving a minimum issue interval of LATENCY+2 cycles.
REQ-023 SHALL support these load modes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- Lanes are selected by addr[1:0] (little-endian).
REQ-024 SHALL support these store modes: 000 SB, 001 SH, 010 SW.
- Only the addressed byte lanes are written.
- Bytes are taken from the low bits of wdata.
REQ-025 SHALL perform the array read or write once, on the edge that enters RESP.
REQ-026 SHALL drive resp_rdata_o=0 for stores.
REQ-027 SHALL raise resp_err_o=1 for any of these faults:
- Half access with addr[0]=1.
- Word access with addr[1:0]!=0.
- Word index addr[31:2]>=DEPTH_WORDS.
- Illegal mode: loads 011, 110 and 111; stores with mode above 010.
REQ-028 SHALL, for a faulting request, write nothing, return resp_rdata_o=0, and still follow the full latency and handshake.
REQ-029 SHALL ignore req_valid_i while busy; inputs that change during WAIT or RESP SHALL have no effect.
REQ-030 SHALL treat a request asserted in the same cycle as a response is consumed as not accepted; it is accepted in the following IDLE cycle.

Reset
REQ-031 SHALL, with rst_i=1 at an edge, reset the block as follows:
- State goes to IDLE and the counter to 0.
- req_ready_o=1 from the next cycle.
- resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, busy_o=0.
REQ-032 SHALL, on reset during WAIT, abort the request with no array write; reset during RESP SHALL drop the pending response.
REQ-033 SHALL NOT clear the data array on reset.

Verification
REQ-034 SHALL cover: with LATENCY=2, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid_o 3 cycles after each handshake, resp_rdata_o=0xDEADBEEF, resp_err_o=0.
REQ-035 SHALL cover: SB 0x80 to addr 0x13 over word 0x00000000, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
REQ-036 SHALL cover: LH at 0x11 and SW at 0x12 -> resp_err_o=1, resp_rdata_o=0, and a following LW 0x10 shows the word unchanged.
REQ-037 SHALL cover: resp_ready_i held 0 for 5 cycles -> resp_valid_o and data stable for all 5 cycles, and req_ready_o=0 throughout.
REQ-038 SHALL cover: SW issued, then rst_i pulsed during WAIT -> no response, req_ready_o=1 next cycle, and a later LW returns the old word value.
REQ-039 SHALL cover: with LATENCY=0, back-to-back LW requests -> resp_valid_o 1 cycle after each handshake, and a 2-cycle issue interval with resp_ready_i=1.
